dpwm_capture: RTL and testbench

- Measures the gate-drive pair produced by the DPWM path and reports period, high time, A-fall→B-rise dead time and shoot-through faults.
- Inputs are the two switch signals, looped back via GPIO, each sampled asynchronously.
- Results feed closed-loop checking and LCD display of the actual fs, duty and dead time against the commanded maxcount, duty and dt settings.
- Sits beside the DPWM in the top level, clocked from CLOCK_50.

---
 rtl/dpwm_capture_pkg.sv | 36 +++
 rtl/dpwm_capture_sync_edge.sv | 35 +++
 rtl/dpwm_capture.sv | 187 ++++++++++++++++++
 tb/tb_dpwm_capture.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dpwm_capture_pkg.sv
// Shared types and constants for the DPWM gate-drive capture block.
`default_nettype none

package dpwm_capture_pkg;

  typedef enum logic [1:0] {
    ST_ARM  = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  localparam int CW_DEF     = 10;
  localparam int DW_DEF     = 6;
  localparam int MAXCOUNT_N = 11;

  // Nominal maxcount settings of the DPWM, indexed by frequency step.
  function automatic int maxcount_nominal(input int idx);
    case (idx)
      0:       return 1000;
      1:       return 769;
      2:       return 625;
      3:       return 526;
      4:       return 455;
      5:       return 400;
      6:       return 357;
      7:       return 322;
      8:       return 294;
      9:       return 270;
      10:      return 250;
      default: return 0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/dpwm_capture_sync_edge.sv
// Two-flop synchronizer plus history flop giving level, rise and fall strobes.
`default_nettype none

module sync_edge (
  input  logic CLOCK_50,
  input  logic resetn,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic hist_q;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      hist_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      hist_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~hist_q;
  assign fall_o  = ~sync_q & hist_q;

endmodule

`default_nettype wire

// File: rtl/dpwm_capture.sv
// Measures period, high time and A-fall to B-rise dead time of a gate-drive pair,
// with timeout/stuck detection and a sticky shoot-through flag.
`default_nettype none

module dpwm_capture
  import dpwm_capture_pkg::*;
#(
  parameter int CW      = CW_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = 1023
) (
  input  logic          CLOCK_50,
  input  logic          resetn,
  input  logic          EN,
  input  logic          pwm_a,
  input  logic          pwm_b,
  input  logic          clear_fault,
  output logic [CW-1:0] period_count,
  output logic [CW-1:0] high_count,
  output logic [DW-1:0] dead_count,
  output logic          meas_valid,
  output logic          timeout,
  output logic          stuck_level,
  output logic          shoot_thru
);

  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [DW-1:0] DMAX = '1;
  localparam logic [CW-1:0] TMO  = CW'(TIMEOUT);

  logic a_s, a_rise, a_fall;
  logic b_s, b_rise, b_fall_unused;

  sync_edge u_sync_a (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .d_i      (pwm_a),
    .level_o  (a_s),
    .rise_o   (a_rise),
    .fall_o   (a_fall)
  );

  sync_edge u_sync_b (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .d_i      (pwm_b),
    .level_o  (b_s),
    .rise_o   (b_rise),
    .fall_o   (b_fall_unused)
  );

  state_e        state_q, state_d;
  logic [CW-1:0] per_q, per_d, high_q, high_d;
  logic [DW-1:0] dead_q, dead_d;
  logic          dead_run_q, dead_run_d, b_seen_q, b_seen_d;
  logic [CW-1:0] pub_per_q, pub_per_d, pub_high_q, pub_high_d;
  logic [DW-1:0] pub_dead_q, pub_dead_d;
  logic          valid_q, valid_d, tmo_q, tmo_d;
  logic          stuck_q, stuck_d, shoot_q, shoot_d;

  logic [CW-1:0] per_inc, high_inc;
  logic [DW-1:0] dead_inc;

  assign per_inc  = (per_q  == CMAX) ? per_q  : per_q  + CW'(1);
  assign high_inc = (high_q == CMAX) ? high_q : high_q + CW'(1);
  assign dead_inc = (dead_q == DMAX) ? dead_q : dead_q + DW'(1);

  always_comb begin
    state_d    = state_q;
    per_d      = per_q;
    high_d     = high_q;
    dead_d     = dead_q;
    dead_run_d = dead_run_q;
    b_seen_d   = b_seen_q;
    pub_per_d  = pub_per_q;
    pub_high_d = pub_high_q;
    pub_dead_d = pub_dead_q;
    valid_d    = 1'b0;
    tmo_d      = 1'b0;
    stuck_d    = clear_fault ? 1'b0 : stuck_q;
    // Set has priority over a coincident clear.
    shoot_d    = (a_s & b_s) | (shoot_q & ~clear_fault);

    if (!EN) begin
      state_d    = ST_ARM;
      per_d      = '0;
      high_d     = '0;
      dead_d     = '0;
      dead_run_d = 1'b0;
      b_seen_d   = 1'b0;
    end else if (state_q == ST_ARM) begin
      per_d      = '0;
      high_d     = '0;
      dead_d     = '0;
      dead_run_d = 1'b0;
      b_seen_d   = 1'b0;
      if (a_rise) begin
        state_d = ST_HIGH;
        per_d   = CW'(1);
        high_d  = CW'(1);
      end
    end else if (state_q == ST_LOW && a_rise) begin
      // The rise cycle itself is the first cycle of the next period.
      valid_d    = 1'b1;
      pub_per_d  = per_q;
      pub_high_d = high_q;
      pub_dead_d = b_seen_q ? dead_q : '0;
      state_d    = ST_HIGH;
      per_d      = CW'(1);
      high_d     = CW'(1);
      dead_d     = '0;
      dead_run_d = 1'b0;
      b_seen_d   = 1'b0;
    end else if (per_q >= TMO) begin
      tmo_d      = 1'b1;
      stuck_d    = a_s;
      state_d    = ST_ARM;
      per_d      = '0;
      high_d     = '0;
      dead_d     = '0;
      dead_run_d = 1'b0;
      b_seen_d   = 1'b0;
    end else begin
      per_d = per_inc;
      if (state_q == ST_HIGH) begin
        if (a_fall) begin
          state_d    = ST_LOW;
          dead_d     = b_s ? '0 : DW'(1);
          dead_run_d = ~b_s;
          b_seen_d   = b_rise;
        end else begin
          high_d = high_inc;
        end
      end else if (dead_run_q) begin
        if (b_rise) begin
          dead_run_d = 1'b0;
          b_seen_d   = 1'b1;
        end else if (!b_s) begin
          dead_d = dead_inc;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_ARM;
      per_q      <= '0;
      high_q     <= '0;
      dead_q     <= '0;
      dead_run_q <= 1'b0;
      b_seen_q   <= 1'b0;
      pub_per_q  <= '0;
      pub_high_q <= '0;
      pub_dead_q <= '0;
      valid_q    <= 1'b0;
      tmo_q      <= 1'b0;
      stuck_q    <= 1'b0;
      shoot_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      per_q      <= per_d;
      high_q     <= high_d;
      dead_q     <= dead_d;
      dead_run_q <= dead_run_d;
      b_seen_q   <= b_seen_d;
      pub_per_q  <= pub_per_d;
      pub_high_q <= pub_high_d;
      pub_dead_q <= pub_dead_d;
      valid_q    <= valid_d;
      tmo_q      <= tmo_d;
      stuck_q    <= stuck_d;
      shoot_q    <= shoot_d;
    end
  end

  assign period_count = pub_per_q;
  assign high_count   = pub_high_q;
  assign dead_count   = pub_dead_q;
  assign meas_valid   = valid_q;
  assign timeout      = tmo_q;
  assign stuck_level  = stuck_q;
  assign shoot_thru   = shoot_q;

endmodule

`default_nettype wire

// File: tb/tb_dpwm_capture.sv
// Scoreboard bench for dpwm_capture: each publishing rise pushes the period it closes.
`default_nettype none

module tb_dpwm_capture;
  import dpwm_capture_pkg::*;

  localparam int CW  = 10;
  localparam int DW  = 6;
  localparam int TMO = 1023;

  logic          CLOCK_50 = 1'b0;
  logic          resetn = 1'b0;
  logic          EN = 1'b0;
  logic          pwm_a = 1'b0;
  logic          pwm_b = 1'b0;
  logic          clear_fault = 1'b0;
  logic [CW-1:0] period_count, high_count;
  logic [DW-1:0] dead_count;
  logic          meas_valid, timeout, stuck_level, shoot_thru;

  dpwm_capture #(.CW(CW), .DW(DW), .TIMEOUT(TMO)) dut (
    .CLOCK_50     (CLOCK_50),
    .resetn       (resetn),
    .EN           (EN),
    .pwm_a        (pwm_a),
    .pwm_b        (pwm_b),
    .clear_fault  (clear_fault),
    .period_count (period_count),
    .high_count   (high_count),
    .dead_count   (dead_count),
    .meas_valid   (meas_valid),
    .timeout      (timeout),
    .stuck_level  (stuck_level),
    .shoot_thru   (shoot_thru)
  );

  typedef struct packed {
    logic [CW-1:0] per;
    logic [CW-1:0] high;
    logic [DW-1:0] dead;
  } meas_t;

  meas_t exp_q[$];
  meas_t prev;
  meas_t last_pub;
  bit    armed = 1'b0;
  int    n_tests = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    n_tmo_seen = 0;
  int    n_tmo_exp = 0;
  int    tmo_cyc = 0;
  int    c0;
  logic  exp_stuck = 1'b0;

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge CLOCK_50) begin
    meas_t e;
    if (resetn && meas_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'(meas_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        last_pub = e;
        chk("period_count", 32'(period_count), 32'(e.per));
        chk("high_count", 32'(high_count), 32'(e.high));
        chk("dead_count", 32'(dead_count), 32'(e.dead));
      end
    end
    if (resetn && timeout) begin
      n_tmo_seen++;
      tmo_cyc = cyc;
      chk("stuck_level_at_timeout", 32'(stuck_level), 32'(exp_stuck));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  // Idle low cycles lengthen the period that the next rise will close.
  task automatic idle(input int n);
    tick(n);
    prev.per = prev.per + CW'(n);
  endtask

  // dt >= 0: B rises dt cycles after A falls; dt < 0: B rises -dt cycles before A falls.
  task automatic drive_period(input int h, input int l, input int dt, input int en_drop);
    if (armed) exp_q.push_back(prev);
    armed     = 1'b1;
    exp_stuck = 1'b0;
    pwm_a     = 1'b1;
    pwm_b     = 1'b0;
    for (int i = 0; i < h; i++) begin
      if (dt < 0 && i == h + dt) pwm_b = 1'b1;
      @(negedge CLOCK_50);
    end
    pwm_a = 1'b0;
    for (int i = 0; i < l; i++) begin
      if (dt >= 0 && i == dt) pwm_b = 1'b1;
      if (en_drop >= 0 && i == en_drop) EN = 1'b0;
      if (en_drop >= 0 && i == en_drop + 10) EN = 1'b1;
      @(negedge CLOCK_50);
    end
    prev.per  = CW'(h + l);
    prev.high = CW'(h);
    prev.dead = (dt >= 0 && dt < l) ? DW'(dt) : '0;
    if (en_drop >= 0) armed = 1'b0;
    if (h + l > TMO) begin
      armed = 1'b0;
      n_tmo_exp++;
    end
  endtask

  initial begin
    int m;
    prev     = '0;
    last_pub = '0;

    // Reset state
    #5;
    chk("rst_period", 32'(period_count), 32'd0);
    chk("rst_high", 32'(high_count), 32'd0);
    chk("rst_dead", 32'(dead_count), 32'd0);
    chk("rst_valid", 32'(meas_valid), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_stuck", 32'(stuck_level), 32'd0);
    chk("rst_shoot", 32'(shoot_thru), 32'd0);
    tick(3);
    resetn = 1'b1;
    EN     = 1'b1;
    tick(2);

    // Steady train: first period only arms
    for (int i = 0; i < 4; i++) drive_period(150, 207, 3, -1);

    // pwm_a stuck high after a publishing rise
    exp_q.push_back(prev);
    armed     = 1'b0;
    exp_stuck = 1'b1;
    n_tmo_exp++;
    pwm_a = 1'b1;
    pwm_b = 1'b0;
    c0    = cyc;
    tick(1100);
    chk("timeout_latency", 32'(tmo_cyc - c0), 32'd1026);
    chk("timeout_once", 32'(n_tmo_seen), 32'(n_tmo_exp));
    chk("held_period", 32'(period_count), 32'd357);
    chk("held_high", 32'(high_count), 32'd150);
    chk("held_dead", 32'(dead_count), 32'd3);
    chk("stuck_high", 32'(stuck_level), 32'd1);
    pwm_a = 1'b0;
    pwm_b = 1'b1;
    tick(20);
    for (int i = 0; i < 3; i++) drive_period(150, 207, 3, -1);

    // Exact complements, then overlap
    drive_period(150, 207, 0, -1);
    drive_period(150, 207, 0, -1);
    chk("no_shoot_complement", 32'(shoot_thru), 32'd0);
    drive_period(150, 207, -2, -1);
    chk("shoot_set", 32'(shoot_thru), 32'd1);
    drive_period(150, 207, 3, -1);
    chk("shoot_sticky", 32'(shoot_thru), 32'd1);
    clear_fault = 1'b1;
    idle(1);
    clear_fault = 1'b0;
    idle(2);
    chk("shoot_cleared", 32'(shoot_thru), 32'd0);
    chk("stuck_cleared", 32'(stuck_level), 32'd0);

    // EN dropped mid-LOW
    drive_period(150, 207, 3, 50);
    chk("en_held_period", 32'(period_count), 32'(last_pub.per));
    chk("en_held_high", 32'(high_count), 32'(last_pub.high));
    drive_period(150, 207, 3, -1);
    drive_period(150, 207, 3, -1);

    // Reset mid-HIGH
    if (armed) exp_q.push_back(prev);
    pwm_a = 1'b1;
    pwm_b = 1'b0;
    tick(50);
    #3;
    resetn = 1'b0;
    #1;
    chk("mid_rst_period", 32'(period_count), 32'd0);
    chk("mid_rst_high", 32'(high_count), 32'd0);
    chk("mid_rst_dead", 32'(dead_count), 32'd0);
    chk("mid_rst_valid", 32'(meas_valid), 32'd0);
    chk("mid_rst_queue", 32'(exp_q.size()), 32'd0);
    armed = 1'b0;
    @(negedge CLOCK_50);
    pwm_a = 1'b0;
    tick(3);
    resetn = 1'b1;
    tick(2);
    for (int i = 0; i < 3; i++) drive_period(150, 207, 3, -1);

    // Period longer than TIMEOUT, then a 1000-cycle period
    drive_period(150, 950, 3, -1);
    chk("period_le_timeout", 32'(period_count <= CW'(TMO)), 32'd1);
    drive_period(400, 600, 3, -1);
    drive_period(400, 600, 3, -1);

    // A few nominal maxcount settings
    for (int k = 0; k < 3; k++) begin
      m = maxcount_nominal(k);
      drive_period(m * 2 / 5, m - m * 2 / 5, 3, -1);
      drive_period(m * 2 / 5, m - m * 2 / 5, 3, -1);
    end

    // Closing rise publishes the last period
    if (armed) exp_q.push_back(prev);
    pwm_a = 1'b1;
    pwm_b = 1'b0;
    tick(10);
    pwm_a = 1'b0;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick(1);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("timeout_total", 32'(n_tmo_seen), 32'(n_tmo_exp));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
